// File: rtl/ss_job_runner_if.sv
// Start/step/done bundle between a job issuer and ss_job_runner.
interface ss_job_runner_if #(parameter int CNT_W = 8);
    logic             i_w_start;
    logic [CNT_W-1:0] i_len;
    logic             i_stall;
    logic             o_busy;
    logic             o_step;
    logic [CNT_W-1:0] o_idx;
    logic             o_done;
    logic             o_overrun;

    modport master (output i_w_start, i_len, i_stall,
                    input  o_busy, o_step, o_idx, o_done, o_overrun);
    modport slave  (input  i_w_start, i_len, i_stall,
                    output o_busy, o_step, o_idx, o_done, o_overrun);
endinterface

// File: rtl/ss_job_runner.sv
// Runs a fixed-length job of i_len step cycles per accepted start pulse,
// honouring a per-cycle stall, and closes with a one-cycle done pulse.
module ss_job_runner #(
    parameter int CNT_W = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    ss_job_runner_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len_q, idx_q;
    logic             overrun_q;
    logic             accept, adv, last_step;

    // Starts are only taken when not running; DONE accepts for back-to-back jobs.
    assign accept    = bus.i_w_start && (state == IDLE || state == DONE);
    assign adv       = (state == RUN) && !bus.i_stall;
    assign last_step = adv && (idx_q == len_q - CNT_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_q     <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (accept) begin
                len_q <= bus.i_len;
                idx_q <= '0;
            end else if (adv && !last_step) begin
                idx_q <= idx_q + CNT_W'(1);
            end
            if (state == RUN && bus.i_w_start) overrun_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_nxt = (bus.i_len == '0) ? DONE : RUN;
                else        state_nxt = IDLE;
            end
            RUN:     if (last_step) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.o_busy    = (state == RUN) || (state == DONE);
        bus.o_step    = adv;
        bus.o_idx     = idx_q;
        bus.o_done    = (state == DONE);
        bus.o_overrun = overrun_q;
    end
endmodule

// File: tb/tb_ss_job_runner.sv
// Directed scenarios plus random traffic against a step-count reference model.
module tb_ss_job_runner;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ss_job_runner_if #(.CNT_W(CNT_W)) bus ();
    ss_job_runner #(.CNT_W(CNT_W)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int tests = 0, fails = 0;
    // Model: remaining steps of the current job, its length, done-cycle flag, sticky overrun.
    int rem = 0, jl = 0;
    bit m_done = 0, m_ovr = 0;
    int cyc_n, n_step, n_busy, n_done, done_cyc;

    task automatic chk(input string tag, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic clr_stats();
        cyc_n = 0; n_step = 0; n_busy = 0; n_done = 0; done_cyc = -1;
    endtask

    task automatic cyc(input bit st, input int ln, input bit sl, input bit r);
        bit e_step;
        bus.i_w_start = st;
        bus.i_len     = CNT_W'(ln);
        bus.i_stall   = sl;
        rst           = r;
        @(negedge clk);
        e_step = (rem > 0) && !sl;
        chk("busy", int'(bus.o_busy), int'(rem > 0 || m_done));
        chk("step", int'(bus.o_step), int'(e_step));
        if (e_step) chk("idx", int'(bus.o_idx), jl - rem);
        chk("done", int'(bus.o_done), int'(m_done));
        chk("overrun", int'(bus.o_overrun), int'(m_ovr));
        if (bus.o_step) n_step++;
        if (bus.o_busy) n_busy++;
        if (bus.o_done) begin n_done++; done_cyc = cyc_n; end
        cyc_n++;
        if (r) begin
            rem = 0; m_done = 0; m_ovr = 0;
        end else if (rem > 0) begin
            if (st) m_ovr = 1;
            if (!sl) begin
                rem--;
                m_done = (rem == 0);
            end
        end else begin
            m_done = 0;
            if (st) begin
                jl = ln;
                if (ln == 0) m_done = 1;
                else         rem = ln;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; bus.i_w_start = 1'b0; bus.i_len = '0; bus.i_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_idx", int'(bus.o_idx), 0);
        chk("rst_busy", int'(bus.o_busy), 0);
        idle(2);

        // Basic job of 4
        clr_stats();
        cyc(1, 4, 0, 0);
        idle(7);
        chk("basic_steps", n_step, 4);
        chk("basic_busy", n_busy, 5);
        chk("basic_done_at", done_cyc, 5);

        // Stall in the second RUN cycle
        clr_stats();
        cyc(1, 3, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        idle(5);
        chk("stall_steps", n_step, 3);
        chk("stall_done_at", done_cyc, 5);

        // Zero length, then back-to-back start during its DONE
        clr_stats();
        cyc(1, 0, 0, 0);
        cyc(1, 2, 0, 0);
        idle(5);
        chk("b2b_steps", n_step, 2);
        chk("b2b_dones", n_done, 2);
        chk("b2b_done_at", done_cyc, 4);

        // Overrun: extra start while idx==2
        clr_stats();
        cyc(1, 5, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 9, 0, 0);
        idle(6);
        chk("ovr_steps", n_step, 5);
        chk("ovr_dones", n_done, 1);
        chk("ovr_sticky", int'(bus.o_overrun), 1);

        // Reset at idx 3 of 8
        clr_stats();
        cyc(1, 8, 0, 0);
        idle(3);
        cyc(0, 0, 0, 1);
        chk("mid_rst_busy", int'(bus.o_busy), 0);
        chk("mid_rst_idx", int'(bus.o_idx), 0);
        idle(6);
        chk("mid_rst_dones", n_done, 0);
        clr_stats();
        cyc(1, 1, 0, 0);
        idle(3);
        chk("after_rst_steps", n_step, 1);
        chk("after_rst_done_at", done_cyc, 2);

        // Max length for CNT_W=4
        clr_stats();
        cyc(1, 15, 0, 0);
        idle(18);
        chk("max_steps", n_step, 15);
        chk("max_done_at", done_cyc, 16);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 60) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ss_job_runner.md
# ss_job_runner

Consumes the single-cycle work-start pulse from `SS_detect_start` and executes a fixed-length job of `i_len` step cycles. It emits one `o_step` strobe with an index per accepted step, honours a per-cycle stall, and returns a single-cycle `o_done` pulse. That pulse drives the `i_done` input of `SS_detect_start`, closing the start/done handshake.

## Interface

**Parameters**
- `CNT_W`, default 8: width of the job length and step index. Maximum job length is 2^CNT_W−1.

**Ports**
- `i_clk`, input, 1: sole clock, rising-edge.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `i_w_start`, input, 1: work-start pulse from `SS_detect_start`. Sampled on every rising edge.
- `i_len`, input, CNT_W: job length in steps. Sampled only in the cycle where a start is accepted.
- `i_stall`, input, 1: when 1 during RUN, suppresses the step and holds the index.
- `o_busy`, output, 1: 1 in the RUN and DONE states.
- `o_step`, output, 1: step strobe. Equals (state==RUN) && !i_stall; this is combinational from i_stall.
- `o_idx`, output, CNT_W: index of the current step. Valid when o_step=1. Registered.
- `o_done`, output, 1: job-complete pulse, exactly 1 cycle.
- `o_overrun`, output, 1: sticky flag. Set when a start arrives during RUN; cleared only by reset.

## Operation

**FSM states:** IDLE, RUN, DONE. State, `len_q`, `idx_q` and `o_overrun` are registered.

**IDLE**
- On `i_w_start=1`: latch `len_q <= i_len` and set `idx_q <= 0`.
  - If `i_len != 0`, go to RUN.
  - If `i_len == 0`, go directly to DONE. Zero steps are issued and a done pulse is still produced.
- Otherwise stay in IDLE.

**RUN**
- `i_stall=0`: step issued with `o_idx = idx_q`.
  - If `idx_q == len_q−1`, go to DONE.
  - Otherwise `idx_q <= idx_q+1`.
- `i_stall=1`: no step; `idx_q` and state are held. Stalls of any length are allowed.
- `i_w_start=1` in RUN: the start is ignored and `o_overrun <= 1`. The job continues unaffected.

**DONE**
- `o_done=1` for this single cycle.
- If `i_w_start=1` in the same cycle, the new start is accepted with the same rules as IDLE. The next state is RUN, or DONE again if the new `i_len == 0`. This supports back-to-back jobs.
- Otherwise go to IDLE.

**Arithmetic:** the index increment is CNT_W wide and cannot wrap, because `idx_q ≤ len_q−1 ≤ 2^CNT_W−2` before the increment.

## Timing

**Reset**
- `i_rst` sampled high: next state IDLE, `idx_q=0`, `len_q=0`, `o_overrun=0`.
- Outputs after reset: `o_busy=0`, `o_step=0`, `o_idx=0`, `o_done=0`.
- Reset takes precedence over every other input in the same cycle, including during RUN or DONE. An in-flight job is dropped and no `o_done` is issued.

**Latency**
- Start sampled at edge k: RUN is active from cycle k+1, and the first step can occur in cycle k+1.
- Unstalled job of length N: steps occur in cycles k+1 … k+N, and `o_done` is in cycle k+N+1. Total start-to-done is N+1 cycles.
- Each stall cycle adds one cycle to that total.
- `i_len == 0`: `o_done` is in cycle k+1.

**Other rules**
- `o_busy` falls in the cycle after DONE, unless a back-to-back start was accepted in DONE.
- A start arriving in the same cycle as the last RUN step is treated as a RUN-state start: it is ignored and sets overrun.
- `i_len` is not sampled while the block is busy.

## Test plan

- **Basic job:** reset, then `i_w_start=1` with `i_len=4` for one cycle, no stall → `o_step` high for 4 consecutive cycles with `o_idx` 0,1,2,3; `o_done` 1 cycle later; `o_busy` high for 5 cycles.
- **Stall:** `i_len=3`, `i_stall=1` in the 2nd RUN cycle only → `o_idx` sequence 0,(hold),1,2; `o_done` at start+5.
- **Zero length and back-to-back:** `i_len=0` start → `o_done` at start+1 with no `o_step`. Then a start with `i_len=2` asserted during that DONE cycle → steps 0,1 follow immediately, then a second `o_done`.
- **Overrun:** `i_len=5` job with an extra `i_w_start` pulse in RUN at idx 2 → job completes with exactly 5 steps; `o_overrun=1` and it stays 1 after `o_done`.
- **Reset mid-job:** `i_rst` high during RUN at idx 3 of 8 → next cycle `o_busy=0`, `o_idx=0`, no `o_done`; a new start with `i_len=1` afterwards runs normally.
- **Max length:** `CNT_W=4`, `i_len=15` → 15 steps with `o_idx` 0…14, no wrap; `o_done` at start+16.
